eth_frame_gen: RTL and testbench
================================

Name: eth_frame_gen

Overview:
- Avalon-ST Ethernet frame source: the transmit-side counterpart to the MAC receive stream consumed by the internal processing path.
- Drives the TSE MAC transmit interface (32-bit, big-endian byte lanes, ready latency 0) with generated frames.
- Each frame carries fixed MAC addresses, a fixed EtherType, a 16-bit sequence number and a deterministic byte pattern.
- Used as a link traffic source and as stimulus for the receive/processing path on the board.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC address.
SRC_MAC, 48'h0002_0304_0506, source MAC address.
ETHERTYPE, 16'h88B5, EtherType field.

Ports:
sys_clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request for one frame; honoured only in IDLE.
continuous  in  1  level; while high, frames repeat indefinitely.
payload_len  in  11  payload bytes after the 14-byte header; sampled at frame launch.
gap_cycles  in  16  idle cycles between frames; sampled at frame launch.
out_data  out  32  frame data; byte 0 of each beat on [31:24].
out_sop  out  1  first beat of frame.
out_eop  out  1  last beat of frame.
out_empty  out  2  unused bytes in the eop beat; 0 on all other beats.
out_valid  out  1  beat valid.
out_ready  in  1  sink ready.
busy  out  1  high in SEND or GAP.
frame_count  out  32  frames completed since reset; wraps at 2^32.

Behaviour:
- Reset (async, reset_n low):
  - out_valid, out_sop, out_eop, out_empty, out_data = 0.
  - busy = 0, frame_count = 0, seq = 0, state = IDLE.
  - Reset mid-frame abandons the frame immediately; no eop is issued.
- Handshake:
  - A beat transfers on a rising edge with out_valid & out_ready.
  - While out_valid is high and out_ready is low, all out_* hold stable.
  - out_valid never drops mid-frame; the generator inserts no bubbles.
- Length rules:
  - Effective length L = payload_len clamped to the range [46, 1500].
  - Total bytes T = 14 + L.
  - Beats = ceil(T/4). eop-beat out_empty = (4 - T mod 4) mod 4.
  - Unused bytes in the eop beat are 0.
- Frame content (byte index k, 0-based):
  - Bytes 0-5: DST_MAC, MSB first.
  - Bytes 6-11: SRC_MAC, MSB first.
  - Bytes 12-13: ETHERTYPE.
  - Bytes 14-15: seq[15:8], seq[7:0].
  - Byte k >= 16: k[7:0].
- States:
  - IDLE: out_valid = 0. If start | continuous, latch L, gap and seq, then go to SEND. The sop beat is valid on the cycle after the launch edge (1-cycle latency).
  - SEND: the beat counter advances on each transfer. When the eop beat is accepted:
    - frame_count and seq increment, both wrapping.
    - If gap = 0 and continuous = 1: the next frame's sop is valid on the next cycle (back-to-back), with L and gap re-sampled at that edge.
    - Else if gap > 0: go to GAP.
    - Else: go to IDLE.
  - GAP: out_valid = 0 for exactly gap cycles. Then:
    - If continuous = 1: relaunch, with sop valid on the cycle immediately after the last gap cycle.
    - Else: go to IDLE.
- Simultaneous events and mid-frame changes:
  - start in SEND or GAP is ignored.
  - Dropping continuous mid-frame completes the current frame; the frame is not truncated.
  - payload_len and gap_cycles changes mid-frame have no effect until the next launch.
- busy is registered and equals (state != IDLE).

Test Plan:
1. Single frame:
   - Stimulus: payload_len = 60, out_ready = 1, start pulse.
   - Response: 19 beats. Beat0 = 0xFFFFFFFF with sop. Beat1 = 0xFFFF0002. Beat2 = 0x03040506. Beat3 = 0x88B50000. Beat4 = 0x10111213. eop on beat 18 with out_empty = 2 and data 0x48490000. frame_count = 1.
2. Clamp:
   - payload_len = 10 -> 15 beats, out_empty = 0.
   - payload_len = 2000 -> 379 beats, out_empty = 2.
3. Backpressure:
   - Stimulus: out_ready toggles randomly, plus 20-cycle low stretches.
   - Response: data and sop/eop held stable while stalled; byte stream identical to scenario 1.
4. Continuous with gap:
   - Stimulus: continuous = 1, gap_cycles = 3.
   - Response: exactly 3 out_valid-low cycles between the eop transfer and the next sop. The second frame carries seq = 0x0001 in bytes 14-15.
   - With gap_cycles = 0: frames are back-to-back, with sop on the cycle after eop.
5. Reset mid-frame:
   - Stimulus: reset_n asserted at beat 7.
   - Response: outputs 0 asynchronously. After release, start yields a fresh frame with seq = 0 and frame_count = 0 -> 1.
6. Ignored start and continuous drop:
   - Stimulus: start during SEND; continuous dropped mid-frame.
   - Response: the current frame completes, then IDLE. frame_count increments by exactly 1.

Source files
------------

// File: rtl/eth_frame_gen_if.sv
// Avalon-ST transmit bus between the frame generator and the TSE MAC.
// The master drives the beats. The slave returns ready, with ready latency 0.
interface eth_frame_gen_if;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_empty;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_sop,
    output out_eop,
    output out_empty,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_sop,
    input  out_eop,
    input  out_empty,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/eth_frame_gen.sv
// Ethernet frame source: fixed MACs/EtherType, 16-bit sequence number, byte-index payload.
// sop is valid 1 cycle after launch; beats hold stable while out_ready is low; no bubbles within a frame.
module eth_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0002_0304_0506,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [10:0]            payload_len,
  input  logic [15:0]            gap_cycles,
  eth_frame_gen_if.master        tx,
  output logic                   busy,
  output logic [31:0]            frame_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_q, state_n;
  logic [10:0] tot_q, tot_n;
  logic [15:0] gap_q, gap_n;
  logic [15:0] gap_cnt_q, gap_cnt_n;
  logic [8:0]  idx_q, idx_n;
  logic [15:0] seq_q, seq_n;
  logic [31:0] cnt_q, cnt_n;
  logic        launch;

  logic [31:0] data_n;
  logic        sop_n, eop_n, valid_n;
  logic [1:0]  empty_n;
  logic [8:0]  last_n;

  // Total frame bytes: the 14-byte header plus the clamped payload.
  function automatic logic [10:0] total_len(input logic [10:0] plen);
    logic [10:0] l;
    l = plen;
    if (plen < 11'd46)
      l = 11'd46;
    else if (plen > 11'd1500)
      l = 11'd1500;
    return l + 11'd14;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [10:0] k, input logic [15:0] seq,
                                            input logic [10:0] tot);
    logic [15:0][7:0] hdr;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq};
    if (k >= tot)
      return 8'h00;
    else if (k < 11'd16)
      return hdr[~k[3:0]];
    else
      return k[7:0];
  endfunction

  function automatic logic [31:0] beat_word(input logic [8:0] idx, input logic [15:0] seq,
                                            input logic [10:0] tot);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      w[31-8*j -: 8] = frame_byte({idx, 2'b00} + 11'(j), seq, tot);
    return w;
  endfunction

  always_comb begin
    state_n   = state_q;
    tot_n     = tot_q;
    gap_n     = gap_q;
    gap_cnt_n = gap_cnt_q;
    idx_n     = idx_q;
    seq_n     = seq_q;
    cnt_n     = cnt_q;
    launch    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || continuous)
          launch = 1'b1;
      end
      SEND: begin
        if (tx.out_valid && tx.out_ready) begin
          if (tx.out_eop) begin
            seq_n = seq_q + 16'd1;
            cnt_n = cnt_q + 32'd1;
            if (continuous && gap_q == 16'd0) begin
              launch = 1'b1;
            end else if (gap_q != 16'd0) begin
              state_n   = GAP;
              gap_cnt_n = gap_q;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_n = idx_q + 9'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q <= 16'd1) begin
          if (continuous)
            launch = 1'b1;
          else
            state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt_q - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      state_n = SEND;
      tot_n   = total_len(payload_len);
      gap_n   = gap_cycles;
      idx_n   = 9'd0;
    end

    // The output register always holds the beat selected by the next index, so a stall reloads identical values.
    last_n  = 9'((tot_n + 11'd3) >> 2) - 9'd1;
    valid_n = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    empty_n = 2'd0;
    data_n  = 32'd0;
    if (state_n == SEND) begin
      valid_n = 1'b1;
      sop_n   = (idx_n == 9'd0);
      eop_n   = (idx_n == last_n);
      empty_n = eop_n ? (2'd0 - tot_n[1:0]) : 2'd0;
      data_n  = beat_word(idx_n, seq_n, tot_n);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tot_q        <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      idx_q        <= '0;
      seq_q        <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      tx.out_valid <= 1'b0;
      tx.out_sop   <= 1'b0;
      tx.out_eop   <= 1'b0;
      tx.out_empty <= 2'd0;
      tx.out_data  <= 32'd0;
    end else begin
      state_q      <= state_n;
      tot_q        <= tot_n;
      gap_q        <= gap_n;
      gap_cnt_q    <= gap_cnt_n;
      idx_q        <= idx_n;
      seq_q        <= seq_n;
      cnt_q        <= cnt_n;
      busy         <= (state_n != IDLE);
      tx.out_valid <= valid_n;
      tx.out_sop   <= sop_n;
      tx.out_eop   <= eop_n;
      tx.out_empty <= empty_n;
      tx.out_data  <= data_n;
    end
  end

  assign frame_count = cnt_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Scoreboard bench for eth_frame_gen: expected beats are queued at launch and checked by an independent monitor.
module tb_eth_frame_gen;
  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0002_0304_0506;
  localparam logic [15:0] ETY = 16'h88B5;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        continuous;
  logic [10:0] payload_len;
  logic [15:0] gap_cycles;
  logic        busy;
  logic [31:0] frame_count;

  eth_frame_gen_if tx();

  eth_frame_gen dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .start       (start),
    .continuous  (continuous),
    .payload_len (payload_len),
    .gap_cycles  (gap_cycles),
    .tx          (tx),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  int          compared = 0;
  int          mismatched = 0;
  beat_t       exp_q[$];
  logic [15:0] exp_seq = 16'd0;
  logic [31:0] exp_count = 32'd0;

  int          frames_seen = 0;
  int          sop_count = 0;
  int          cur_beats = 0;
  int          last_beats = 0;
  logic [1:0]  last_empty = 2'd0;
  logic [31:0] cap[512];
  int          gap_run = 0;
  int          last_gap = -1;
  bit          counting = 1'b0;
  bit          prev_stall = 1'b0;
  beat_t       prev_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference frame built as a plain byte list, then packed big-endian into beats.
  task automatic push_frame(input int plen, input logic [15:0] seq);
    logic [7:0] b[$];
    int l, t, nb;
    beat_t e;
    l = (plen < 46) ? 46 : ((plen > 1500) ? 1500 : plen);
    t = 14 + l;
    for (int i = 0; i < 6; i++) b.push_back(DST[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(SRC[47-8*i -: 8]);
    b.push_back(ETY[15:8]);
    b.push_back(ETY[7:0]);
    b.push_back(seq[15:8]);
    b.push_back(seq[7:0]);
    for (int k = 16; k < t; k++) b.push_back(8'(k));
    nb = (t + 3) / 4;
    while (b.size() < nb * 4) b.push_back(8'h00);
    for (int i = 0; i < nb; i++) begin
      e.data  = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      e.sop   = (i == 0);
      e.eop   = (i == nb - 1);
      e.empty = (i == nb - 1) ? 2'((4 - t % 4) % 4) : 2'd0;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge sys_clk) begin
    beat_t cur, e;
    if (!reset_n) begin
      prev_stall = 1'b0;
      counting   = 1'b0;
      cur_beats  = 0;
    end else begin
      cur = {tx.out_data, tx.out_sop, tx.out_eop, tx.out_empty};
      if (prev_stall)
        check("stall_hold", {27'd0, tx.out_valid, cur}, {27'd0, 1'b1, prev_beat});
      if (counting) begin
        if (tx.out_valid && tx.out_sop) begin
          last_gap = gap_run;
          counting = 1'b0;
        end else if (!tx.out_valid) begin
          gap_run++;
        end
      end
      if (tx.out_valid && tx.out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL beat_extra: got %0h want no beat at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", {28'd0, cur}, {28'd0, e});
        end
        if (tx.out_sop) begin
          sop_count++;
          cur_beats = 0;
        end
        if (cur_beats < 512) cap[cur_beats] = tx.out_data;
        cur_beats++;
        if (tx.out_eop) begin
          frames_seen++;
          last_beats = cur_beats;
          last_empty = tx.out_empty;
          counting   = 1'b1;
          gap_run    = 0;
        end
      end
      prev_stall = tx.out_valid && !tx.out_ready;
      prev_beat  = cur;
    end
  end

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_seen < target && n < 5000) begin @(posedge sys_clk); #2; n++; end
    if (frames_seen < target) timeout("wait_frames");
  endtask

  task automatic wait_sops(input int target);
    int n = 0;
    while (sop_count < target && n < 5000) begin @(posedge sys_clk); #2; n++; end
    if (sop_count < target) timeout("wait_sops");
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (cur_beats < target && n < 5000) begin @(posedge sys_clk); #2; n++; end
    if (cur_beats < target) timeout("wait_beats");
  endtask

  task automatic launch_one(input int plen);
    payload_len = 11'(plen);
    push_frame(plen, exp_seq);
    exp_seq++;
    exp_count++;
    @(posedge sys_clk); #1 start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
    @(negedge sys_clk);
    check("sop_latency", {61'd0, tx.out_valid, tx.out_sop, busy}, {61'd0, 3'b111});
  endtask

  task automatic run_continuous(input int plen, input logic [15:0] gap, input int exp_gap);
    int base_f, base_s;
    base_f = frames_seen;
    base_s = sop_count;
    payload_len = 11'(plen);
    gap_cycles  = gap;
    push_frame(plen, exp_seq); exp_seq++;
    push_frame(plen, exp_seq); exp_seq++;
    exp_count += 2;
    @(posedge sys_clk); #1 continuous = 1'b1;
    wait_sops(base_s + 2);
    continuous = 1'b0;
    wait_frames(base_f + 2);
    check("gap_len", 64'(last_gap), 64'(exp_gap));
    repeat (int'(gap) + 4) @(posedge sys_clk);
    #2 check("cont_count", {32'd0, frame_count}, {32'd0, exp_count});
    check("cont_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int base;
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0;
    payload_len = 11'd60; gap_cycles = 16'd0; tx.out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_out", {tx.out_data, 27'd0, tx.out_valid, tx.out_sop, tx.out_eop, tx.out_empty},
          64'd0);
    check("rst_status", {31'd0, busy, frame_count}, 64'd0);
    reset_n = 1'b1;

    // Single frame with hand-computed beats.
    base = frames_seen;
    launch_one(60);
    wait_frames(base + 1);
    check("f1_beat0", {32'd0, cap[0]}, 64'hFFFFFFFF);
    check("f1_beat1", {32'd0, cap[1]}, 64'hFFFF0002);
    check("f1_beat2", {32'd0, cap[2]}, 64'h03040506);
    check("f1_beat3", {32'd0, cap[3]}, 64'h88B50000);
    check("f1_beat4", {32'd0, cap[4]}, 64'h10111213);
    check("f1_eop_data", {32'd0, cap[18]}, 64'h48490000);
    check("f1_beats", 64'(last_beats), 64'd19);
    check("f1_empty", {62'd0, last_empty}, 64'd2);
    repeat (2) @(posedge sys_clk);
    #2 check("f1_count", {31'd0, busy, frame_count}, 64'd1);

    // Clamping at both ends.
    base = frames_seen;
    launch_one(10);
    wait_frames(base + 1);
    check("clamp_lo_beats", 64'(last_beats), 64'd15);
    check("clamp_lo_empty", {62'd0, last_empty}, 64'd0);
    launch_one(2000);
    wait_frames(base + 2);
    check("clamp_hi_beats", 64'(last_beats), 64'd379);
    check("clamp_hi_empty", {62'd0, last_empty}, 64'd2);

    // Backpressure: random ready with two 20-cycle low stretches.
    base = frames_seen;
    launch_one(60);
    for (int c = 0; c < 3000 && frames_seen < base + 1; c++) begin
      @(posedge sys_clk); #1;
      tx.out_ready = ((c >= 5 && c < 25) || (c >= 45 && c < 65)) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    tx.out_ready = 1'b1;
    if (frames_seen < base + 1) timeout("bp_frame");
    check("bp_beats", 64'(last_beats), 64'd19);

    // Continuous with a 3-cycle gap, then back-to-back.
    run_continuous(46, 16'd3, 3);
    run_continuous(50, 16'd0, 0);

    // Reset in the middle of a frame.
    launch_one(60);
    wait_beats(7);
    reset_n = 1'b0;
    #1;
    check("midrst_out", {tx.out_data, 27'd0, tx.out_valid, tx.out_sop, tx.out_eop, tx.out_empty},
          64'd0);
    check("midrst_status", {31'd0, busy, frame_count}, 64'd0);
    exp_q.delete();
    exp_seq = 16'd0;
    exp_count = 32'd0;
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    @(posedge sys_clk); #2;
    check("post_rst_count", {32'd0, frame_count}, 64'd0);
    base = frames_seen;
    launch_one(60);
    wait_frames(base + 1);
    repeat (2) @(posedge sys_clk);
    #2 check("post_rst_count1", {32'd0, frame_count}, 64'd1);

    // start during SEND is ignored; dropping continuous completes the frame.
    base = frames_seen;
    payload_len = 11'd50;
    gap_cycles  = 16'd0;
    push_frame(50, exp_seq); exp_seq++; exp_count++;
    @(posedge sys_clk); #1 continuous = 1'b1;
    wait_sops(sop_count + 1);
    wait_beats(3);
    continuous  = 1'b0;
    payload_len = 11'd200;
    start       = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
    wait_frames(base + 1);
    repeat (20) @(posedge sys_clk);
    #2;
    check("drop_count", {32'd0, frame_count}, {32'd0, exp_count});
    check("drop_idle", {63'd0, busy}, 64'd0);
    check("drop_beats", 64'(last_beats), 64'd16);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
